// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared encodings and constants for the MIPS pipeline sequencing controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mips_ctrl_pkg;

   // FSM state encoding, also exported on the debug state port
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_HALTED   = 2'd3;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      MEM_WAIT = ST_MEM_WAIT,
      DRAIN    = ST_DRAIN,
      HALTED   = ST_HALTED
   } ctrl_state_e;

   localparam logic [2:0] REG_ZERO             = 3'd0;
   localparam int         DEFAULT_DRAIN_CYCLES = 3;

   // A load into the zero register never creates a dependency.
   function automatic logic load_use_hit(input logic       ex_mem_read,
                                         input logic [2:0] ex_rt,
                                         input logic [2:0] id_rs,
                                         input logic [2:0] id_rt,
                                         input logic       id_uses_rt);
      return ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Bundle of hazard inputs and pipeline enable/flush outputs of the sequencing controller.
// Latency: n/a (wires only).
// Backpressure: n/a; master = controller (drives enables), slave = datapath (drives hazard info).
interface pipeline_ctrl_unit_if #(
   parameter int CNT_W = 16
);
   // hazard information from the datapath
   logic [2:0]       if_id_rs;
   logic [2:0]       if_id_rt;
   logic             id_uses_rt;
   logic             id_halt;
   logic             id_ex_memRead;
   logic [2:0]       id_ex_rt;
   logic             ex_mem_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   // pipeline register control
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   // status / debug
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  if_id_rs, if_id_rt, id_uses_rt, id_halt, id_ex_memRead, id_ex_rt,
             ex_mem_branch_taken, mem_req, mem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush,
             halted, state, stall_cnt, flush_cnt
   );

   modport slave (
      output if_id_rs, if_id_rt, id_uses_rt, id_halt, id_ex_memRead, id_ex_rt,
             ex_mem_branch_taken, mem_req, mem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush,
             halted, state, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr or rst returns it to 0.
// Latency: count visible one clk after the inc cycle.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (async, active-high), inc, clr, cnt[W-1:0].
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Sequencing controller for the 5-stage pipeline: load-use stall, branch flush, memory wait, HALT drain.
// Latency: enables/flushes are combinational from state and inputs (zero cycle); state updates on posedge clk.
// Backpressure: mem_req & !mem_ready freezes every pipeline register until mem_ready.
// Ports: clk, rst (async, active-high), bus (pipeline_ctrl_unit_if.master).
module pipeline_ctrl_unit
   import mips_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_ctrl_unit_if.master bus
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   ctrl_state_e   state_q, state_nxt;
   logic [DW-1:0] drain_q, drain_nxt;
   logic          ret_drain_q, ret_drain_nxt;

   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush, halted;
   logic flush_evt, freeze, in_drain, load_use;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         drain_q     <= '0;
         ret_drain_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         drain_q     <= drain_nxt;
         ret_drain_q <= ret_drain_nxt;
      end
   end

   // While waiting on memory, only mem_ready matters; elsewhere the access must be pending.
   assign freeze   = (state_q == MEM_WAIT) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
   // The cycle that leaves MEM_WAIT behaves as the state it came from.
   assign in_drain = (state_q == DRAIN) || ((state_q == MEM_WAIT) && ret_drain_q);
   assign load_use = load_use_hit(bus.id_ex_memRead, bus.id_ex_rt, bus.if_id_rs,
                                  bus.if_id_rt, bus.id_uses_rt);

   always_comb begin
      state_nxt     = state_q;
      drain_nxt     = drain_q;
      ret_drain_nxt = ret_drain_q;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      halted        = 1'b0;
      flush_evt     = 1'b0;

      if (state_q == HALTED) begin
         halted = 1'b1;
      end else if (freeze) begin
         state_nxt = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            ret_drain_nxt = (state_q == DRAIN);
         end
      end else if (bus.ex_mem_branch_taken) begin
         // Branch in MEM is older than anything in ID, so it also cancels a pending HALT.
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
         {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
         flush_evt = 1'b1;
         state_nxt = RUN;
         drain_nxt = '0;
      end else if (in_drain || load_use || bus.id_halt) begin
         // Hold PC and IF/ID, push a bubble into ID/EX, let older work advance.
         {id_ex_en, ex_mem_en, mem_wb_en} = '1;
         id_ex_flush = 1'b1;
         if (in_drain) begin
            drain_nxt = drain_q - DW'(1);
            state_nxt = (drain_q <= DW'(1)) ? HALTED : DRAIN;
         end else if (load_use) begin
            state_nxt = RUN;
         end else begin
            drain_nxt = DW'(DRAIN_CYCLES);
            state_nxt = DRAIN;
         end
      end else begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
         state_nxt = RUN;
      end

      // During reset every register loads a bubble.
      if (rst) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
         {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
         halted    = 1'b0;
         flush_evt = 1'b0;
      end
   end

   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (!pc_en && (state_q != HALTED)),
      .clr (1'b0),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_evt),
      .clr (1'b0),
      .cnt (flush_cnt)
   );

   assign bus.pc_en        = pc_en;
   assign bus.if_id_en     = if_id_en;
   assign bus.id_ex_en     = id_ex_en;
   assign bus.ex_mem_en    = ex_mem_en;
   assign bus.mem_wb_en    = mem_wb_en;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_flush  = id_ex_flush;
   assign bus.ex_mem_flush = ex_mem_flush;
   assign bus.halted       = halted;
   assign bus.state        = state_q;
   assign bus.stall_cnt    = stall_cnt;
   assign bus.flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: directed scenarios plus random stimulus against a behavioural model.
// Latency: outputs compared at negedge, model advances at posedge.
// Backpressure: exercised through random and directed mem_req/mem_ready patterns.
module tb_pipeline_ctrl_unit;

   localparam int DRAIN = 3;
   localparam int SAT   = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_ctrl_unit_if #(.CNT_W(16)) bus ();

   pipeline_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: context flags rather than a state register.
   bit m_stop = 0, m_wait = 0, m_drain = 0;
   int m_left = 0, m_stall = 0, m_flush = 0;
   bit n_stop, n_wait, n_drain;
   int n_left, n_stall, n_flush;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= SAT) ? SAT : v + 1;
   endfunction

   // Wait for the negedge, derive expected outputs from the rules, compare.
   task automatic sample();
      bit pc, ifid, idex, exmem, memwb, fi, fd, fe, hl, lu;
      int e_state;
      @(negedge clk);
      {pc, ifid, idex, exmem, memwb, fi, fd, fe, hl} = '0;
      n_stop = m_stop; n_wait = m_wait; n_drain = m_drain;
      n_left = m_left; n_stall = m_stall; n_flush = m_flush;
      lu = bus.id_ex_memRead && bus.id_ex_rt != 3'd0 &&
           (bus.id_ex_rt == bus.if_id_rs || (bus.id_uses_rt && bus.id_ex_rt == bus.if_id_rt));
      e_state = m_stop ? 3 : m_wait ? 1 : m_drain ? 2 : 0;
      if (rst) begin
         {pc, ifid, idex, exmem, memwb, fi, fd, fe} = '1;
         e_state = 0;
         n_stop = 0; n_wait = 0; n_drain = 0; n_left = 0; n_stall = 0; n_flush = 0;
      end else if (m_stop) begin
         hl = 1;
      end else if (m_wait ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready)) begin
         n_wait = 1;
      end else begin
         n_wait = 0;
         if (bus.ex_mem_branch_taken) begin
            {pc, ifid, idex, exmem, memwb, fi, fd, fe} = '1;
            n_flush = sat_inc(m_flush);
            n_drain = 0;
         end else if (m_drain || lu || bus.id_halt) begin
            {idex, exmem, memwb, fd} = '1;
            if (m_drain) begin
               n_left = m_left - 1;
               if (n_left <= 0) begin
                  n_stop = 1;
                  n_drain = 0;
               end
            end else if (!lu) begin
               n_drain = 1;
               n_left = DRAIN;
            end
         end else begin
            {pc, ifid, idex, exmem, memwb} = '1;
         end
      end
      if (!rst && !m_stop && !pc) n_stall = sat_inc(m_stall);

      chk("ctrl", {23'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                   bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.halted},
                  {23'd0, pc, ifid, idex, exmem, memwb, fi, fd, fe, hl});
      chk("state", {30'd0, bus.state}, 32'(e_state));
      chk("stall_cnt", {16'd0, bus.stall_cnt}, rst ? 32'd0 : 32'(m_stall));
      chk("flush_cnt", {16'd0, bus.flush_cnt}, rst ? 32'd0 : 32'(m_flush));
   endtask

   task automatic advance();
      @(posedge clk);
      m_stop = n_stop; m_wait = n_wait; m_drain = n_drain;
      m_left = n_left; m_stall = n_stall; m_flush = n_flush;
      #1;
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   task automatic idle();
      bus.if_id_rs = 3'd0; bus.if_id_rt = 3'd0; bus.id_uses_rt = 1'b0; bus.id_halt = 1'b0;
      bus.id_ex_memRead = 1'b0; bus.id_ex_rt = 3'd0; bus.ex_mem_branch_taken = 1'b0;
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      // Reset state
      sample();
      chk("rst_pc_en", 32'(bus.pc_en), 32'd1);
      chk("rst_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      advance();
      rst = 1'b0;

      // Load-use stall for exactly one cycle
      bus.id_ex_memRead = 1; bus.id_ex_rt = 3'd3; bus.if_id_rs = 3'd3;
      sample();
      chk("lu_pc_en", 32'(bus.pc_en), 32'd0);
      chk("lu_if_id_en", 32'(bus.if_id_en), 32'd0);
      chk("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
      advance();
      idle();
      sample();
      chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      chk("lu_released", 32'(bus.pc_en), 32'd1);
      advance();

      // Zero-register load never stalls
      bus.id_ex_memRead = 1; bus.id_ex_rt = 3'd0; bus.if_id_rs = 3'd0;
      sample();
      chk("zero_pc_en", 32'(bus.pc_en), 32'd1);
      advance();
      idle();
      sample();
      chk("zero_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      advance();

      // Branch beats load-use
      do_reset();
      bus.ex_mem_branch_taken = 1; bus.id_ex_memRead = 1; bus.id_ex_rt = 3'd2; bus.if_id_rs = 3'd2;
      sample();
      chk("br_flushes", {29'd0, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}, 32'd7);
      chk("br_pc_en", 32'(bus.pc_en), 32'd1);
      advance();
      idle();
      sample();
      chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      advance();

      // Memory wait with a branch pending in MEM
      do_reset();
      bus.mem_req = 1; bus.mem_ready = 0; bus.ex_mem_branch_taken = 1;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("mw_frozen", {27'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 32'd0);
         advance();
      end
      bus.mem_ready = 1;
      sample();
      chk("mw_state", 32'(bus.state), 32'd1);
      chk("mw_release_flush", 32'(bus.if_id_flush), 32'd1);
      chk("mw_release_pc_en", 32'(bus.pc_en), 32'd1);
      advance();
      idle();
      sample();
      chk("mw_back_run", 32'(bus.state), 32'd0);
      chk("mw_stall_cnt", 32'(bus.stall_cnt), 32'd4);
      chk("mw_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      advance();

      // HALT drain to HALTED
      do_reset();
      bus.id_halt = 1;
      sample();
      chk("halt_pc_en", 32'(bus.pc_en), 32'd0);
      advance();
      for (int i = 0; i < DRAIN; i++) begin
         sample();
         chk("drain_state", 32'(bus.state), 32'd2);
         advance();
      end
      sample();
      chk("halted_state", 32'(bus.state), 32'd3);
      chk("halted_flag", 32'(bus.halted), 32'd1);
      chk("halted_stall_cnt", 32'(bus.stall_cnt), 32'd4);
      advance();
      sample();
      chk("halted_no_count", 32'(bus.stall_cnt), 32'd4);
      advance();

      // Branch in drain cycle 2 cancels the halt
      do_reset();
      bus.id_halt = 1;
      cyc();
      cyc();
      bus.id_halt = 0; bus.ex_mem_branch_taken = 1;
      sample();
      chk("cancel_state", 32'(bus.state), 32'd2);
      chk("cancel_flush", 32'(bus.if_id_flush), 32'd1);
      advance();
      idle();
      sample();
      chk("cancel_run", 32'(bus.state), 32'd0);
      chk("cancel_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      advance();

      // Reset mid-drain
      bus.id_halt = 1;
      cyc();
      cyc();
      rst = 1;
      sample();
      chk("rst_drain_state", 32'(bus.state), 32'd0);
      chk("rst_drain_stall", 32'(bus.stall_cnt), 32'd0);
      advance();
      rst = 0;
      idle();

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom % 400 == 0) || (m_stop && ($urandom % 16 == 0));
         bus.mem_req             = ($urandom % 4 == 0);
         bus.mem_ready           = ($urandom % 2 == 0);
         bus.ex_mem_branch_taken = ($urandom % 8 == 0);
         bus.id_ex_memRead       = ($urandom % 3 == 0);
         bus.id_ex_rt            = 3'($urandom % 4);
         bus.if_id_rs            = 3'($urandom % 4);
         bus.if_id_rt            = 3'($urandom % 4);
         bus.id_uses_rt          = 1'($urandom % 2);
         bus.id_halt             = ($urandom % 40 == 0);
         cyc();
      end
      rst = 0;

      // Saturation of stall_cnt through a very long memory wait
      do_reset();
      bus.mem_req = 1; bus.mem_ready = 0;
      repeat (SAT + 5) cyc();
      sample();
      chk("stall_saturate", 32'(bus.stall_cnt), 32'hFFFF);
      advance();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
